// File: rtl/comp_mon_pkg.sv
// Shared types and helpers for the complementary-pair monitor.
// Used by comp_pair_chan, comp_pair_monitor and comp_pair_monitor_if.
package comp_mon_pkg;

    typedef enum logic [1:0] {OK, PEND, FAIL} state_t;

    function automatic int sel_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // Increment that sticks at max_v instead of wrapping.
    function automatic longint unsigned sat_inc(input longint unsigned v,
                                                input longint unsigned max_v);
        return (v >= max_v) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/comp_pair_monitor_if.sv
// Bus between a status block (master) and comp_pair_monitor (slave).
// Valid/ready: none; every field is a level sampled on each rising clk edge.
interface comp_pair_monitor_if #(
    parameter int NCH   = 4,
    parameter int W     = 1,
    parameter int CNT_W = 8,
    parameter int SEL_W = comp_mon_pkg::sel_width(NCH)
);
    logic               en;
    logic               clr;
    logic [NCH*W-1:0]   a;
    logic [NCH*W-1:0]   b;
    logic [SEL_W-1:0]   cnt_sel;
    logic [NCH-1:0]     fail_now;
    logic [NCH-1:0]     err_sticky;
    logic               any_err;
    logic [CNT_W-1:0]   cnt_out;
    logic [2*NCH-1:0]   state_dbg;

    modport master (output en, clr, a, b, cnt_sel,
                    input  fail_now, err_sticky, any_err, cnt_out, state_dbg);
    modport slave  (input  en, clr, a, b, cnt_sel,
                    output fail_now, err_sticky, any_err, cnt_out, state_dbg);
endinterface

// File: rtl/comp_pair_chan.sv
// One monitored pair: OK/PEND/FAIL glitch filter, sticky error and saturating count.
// Optional CMP_MON_ASSERT_EN adds FAIL-entry reporting and a run-range check.
module comp_pair_chan
    import comp_mon_pkg::*;
#(
    parameter int W     = 1,
    parameter int TOL   = 2,
    parameter int CNT_W = 8,
    parameter int CH    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             fail_now,
    output logic             err_sticky,
    output logic [CNT_W-1:0] viol_cnt,
    output logic [1:0]       state_dbg
);
    localparam int RUN_W = (TOL < 1) ? 1 : $clog2(TOL + 1);
    localparam logic [RUN_W-1:0] TOL_R = RUN_W'(TOL);
    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    state_t           state;
    logic [RUN_W-1:0] run;
    logic             mismatch;
    logic             enter_fail;

    assign mismatch = (b != ~a);

    // Disabled monitoring never enters FAIL, so sticky/counter stay frozen.
    always_comb begin
        enter_fail = 1'b0;
        if (en && mismatch) begin
            if (state == OK && TOL == 0)        enter_fail = 1'b1;
            if (state == PEND && run == TOL_R)  enter_fail = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= OK;
            run        <= '0;
            err_sticky <= 1'b0;
            viol_cnt   <= '0;
        end else begin
            if (!en) begin
                state <= OK;
                run   <= '0;
            end else begin
                case (state)
                    OK: if (mismatch) begin
                        if (TOL == 0) state <= FAIL;
                        else begin
                            state <= PEND;
                            run   <= RUN_W'(1);
                        end
                    end
                    PEND: if (!mismatch) begin
                        state <= OK;
                        run   <= '0;
                    end else if (run == TOL_R) state <= FAIL;
                    else run <= run + RUN_W'(1);
                    FAIL: if (!mismatch) begin
                        state <= OK;
                        run   <= '0;
                    end
                    default: begin
                        state <= OK;
                        run   <= '0;
                    end
                endcase
            end
            // A FAIL entry on the same edge as clr wins and restarts the count at 1.
            if (enter_fail) begin
                err_sticky <= 1'b1;
                viol_cnt   <= clr ? CNT_W'(1) : CNT_W'(sat_inc(64'(viol_cnt), CNT_MAX));
            end else if (clr) begin
                err_sticky <= 1'b0;
                viol_cnt   <= '0;
            end
        end
    end

    assign fail_now  = (state == FAIL);
    assign state_dbg = state;

`ifdef CMP_MON_ASSERT_EN
    always @(posedge clk) begin
        if (!rst) begin
            assert (!enter_fail)
                else $display("%0t comp_pair_chan[%0d] fail entry a=%h b=%h", $time, CH, a, b);
            assert (run <= TOL_R)
                else $display("%0t comp_pair_chan[%0d] run=%0d above tolerance", $time, CH, run);
        end
    end
`endif

endmodule

// File: rtl/comp_pair_monitor.sv
// NCH-channel complementary-pair monitor: per-channel filters, counter readback mux, any_err.
// Build option CMP_MON_ASSERT_EN enables per-channel simulation assertions.
module comp_pair_monitor
    import comp_mon_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int W     = 1,
    parameter int TOL   = 2,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    comp_pair_monitor_if.slave bus
);
    localparam int SEL_W = sel_width(NCH);

    logic [CNT_W-1:0] cnt_arr [NCH];
    logic [NCH-1:0]   fail_vec;
    logic [NCH-1:0]   sticky_vec;
    logic [2*NCH-1:0] state_vec;
    logic [CNT_W-1:0] cnt_mux;

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        comp_pair_chan #(
            .W(W), .TOL(TOL), .CNT_W(CNT_W), .CH(c)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .en         (bus.en),
            .clr        (bus.clr),
            .a          (bus.a[c*W +: W]),
            .b          (bus.b[c*W +: W]),
            .fail_now   (fail_vec[c]),
            .err_sticky (sticky_vec[c]),
            .viol_cnt   (cnt_arr[c]),
            .state_dbg  (state_vec[2*c +: 2])
        );
    end

    // Selects with no matching channel (cnt_sel >= NCH) read as zero.
    always_comb begin
        cnt_mux = '0;
        for (int i = 0; i < NCH; i++) begin
            if (bus.cnt_sel == SEL_W'(i)) cnt_mux = cnt_arr[i];
        end
    end

    assign bus.fail_now   = fail_vec;
    assign bus.err_sticky = sticky_vec;
    assign bus.any_err    = |sticky_vec;
    assign bus.cnt_out    = cnt_mux;
    assign bus.state_dbg  = state_vec;

endmodule

// File: tb/tb_comp_pair_monitor.sv
// Directed bench: dut_a (NCH=4, W=2, TOL=2, CNT_W=2) and dut_b (NCH=5, W=2, TOL=0, CNT_W=8).
module tb_comp_pair_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    comp_pair_monitor_if #(.NCH(4), .W(2), .CNT_W(2)) if_a ();
    comp_pair_monitor_if #(.NCH(5), .W(2), .CNT_W(8)) if_b ();

    comp_pair_monitor #(.NCH(4), .W(2), .TOL(2), .CNT_W(2)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a.slave)
    );
    comp_pair_monitor #(.NCH(5), .W(2), .TOL(0), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b.slave)
    );

    localparam logic [7:0] A_GOOD = 8'h55;
    localparam logic [7:0] B_GOOD = 8'hAA;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("comparison %s", tag);
        end
    endtask

    task automatic chk_cnt_a(input string tag, input int ch, input int exp);
        if_a.cnt_sel = 2'(ch);
        #1;
        chk(tag, 32'(if_a.cnt_out), 32'(exp));
    endtask

    task automatic chk_cnt_b(input string tag, input int sel, input int exp);
        if_b.cnt_sel = 3'(sel);
        #1;
        chk(tag, 32'(if_b.cnt_out), 32'(exp));
    endtask

    // b pattern for dut_a with channel c's complement broken.
    function automatic logic [7:0] bad_b(input int c);
        logic [7:0] v;
        v = B_GOOD;
        v[c*2 +: 2] = 2'b11;
        return v;
    endfunction

    initial begin
        int hi_cycles;
        if_a.en = 1'b1; if_a.clr = 1'b0; if_a.a = A_GOOD; if_a.b = B_GOOD; if_a.cnt_sel = '0;
        if_b.en = 1'b1; if_b.clr = 1'b0; if_b.a = 10'h155; if_b.b = 10'h2AA; if_b.cnt_sel = '0;

        // Reset and a long run of complementary pairs
        tick(); tick();
        rst = 1'b0;
        chk("reset_fail_now", 32'(if_a.fail_now), 32'h0);
        chk("reset_sticky",   32'(if_a.err_sticky), 32'h0);
        chk("reset_any_err",  32'(if_a.any_err), 32'h0);
        chk("reset_state",    32'(if_a.state_dbg), 32'h0);
        chk("reset_b_fail",   32'(if_b.fail_now), 32'h0);
        repeat (20) tick();
        chk("clean_fail_now", 32'(if_a.fail_now), 32'h0);
        chk("clean_any_err",  32'(if_a.any_err), 32'h0);
        for (int c = 0; c < 4; c++) chk_cnt_a("clean_cnt", c, 0);

        // Ch1: 2-cycle mismatch is tolerated
        if_a.b = bad_b(1);
        tick(); tick();
        chk("glitch2_fail_now", 32'(if_a.fail_now), 32'h0);
        chk("glitch2_state",    32'(if_a.state_dbg), 32'h04);
        if_a.b = B_GOOD;
        tick();
        chk("glitch2_after", 32'(if_a.fail_now), 32'h0);
        chk("glitch2_sticky", 32'(if_a.err_sticky), 32'h0);
        chk_cnt_a("glitch2_cnt1", 1, 0);

        // Ch1: 3-cycle mismatch reaches FAIL at edge k+2
        if_a.b = bad_b(1);
        tick();
        chk("hold3_k",   32'(if_a.fail_now), 32'h0);
        tick();
        chk("hold3_k1",  32'(if_a.fail_now), 32'h0);
        tick();
        chk("hold3_k2",       32'(if_a.fail_now), 32'h2);
        chk("hold3_sticky",   32'(if_a.err_sticky), 32'h2);
        chk("hold3_any_err",  32'(if_a.any_err), 32'h1);
        chk_cnt_a("hold3_cnt1", 1, 1);
        if_a.b = B_GOOD;
        tick();
        chk("hold3_release", 32'(if_a.fail_now), 32'h0);

        // Ch0: 10-cycle mismatch counted once, FAIL high for 8 cycles
        if_a.b = bad_b(0);
        hi_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (if_a.fail_now[0]) hi_cycles++;
        end
        chk("long_hi_cycles", 32'(hi_cycles), 32'd8);
        chk("long_still_fail", 32'(if_a.fail_now), 32'h1);
        if_a.b = B_GOOD;
        tick();
        chk("long_release", 32'(if_a.fail_now), 32'h0);
        chk("long_sticky",  32'(if_a.err_sticky), 32'h3);
        chk_cnt_a("long_cnt0", 0, 1);

        // Ch3: five episodes saturate a 2-bit counter at 3
        for (int e = 1; e <= 5; e++) begin
            if_a.b = bad_b(3);
            tick(); tick(); tick();
            if_a.b = B_GOOD;
            tick();
            if (e == 1) chk_cnt_a("sat_ep1", 3, 1);
            if (e == 3) chk_cnt_a("sat_ep3", 3, 3);
        end
        chk_cnt_a("sat_ep5", 3, 3);
        chk("sat_sticky", 32'(if_a.err_sticky), 32'hB);

        // clr on the same edge as a sixth FAIL entry on ch3
        if_a.b = bad_b(3);
        tick(); tick();
        if_a.clr = 1'b1;
        tick();
        if_a.clr = 1'b0;
        chk("clr_entry_fail_now", 32'(if_a.fail_now), 32'h8);
        chk("clr_entry_sticky",   32'(if_a.err_sticky), 32'h8);
        chk_cnt_a("clr_entry_cnt3", 3, 1);
        chk_cnt_a("clr_entry_cnt0", 0, 0);
        chk_cnt_a("clr_entry_cnt1", 1, 0);
        if_a.b = B_GOOD;
        tick();

        // en=0 while ch2 mismatches: nothing moves, counts hold
        if_a.en = 1'b0;
        if_a.b  = bad_b(2);
        repeat (5) tick();
        chk("dis_fail_now", 32'(if_a.fail_now), 32'h0);
        chk("dis_state",    32'(if_a.state_dbg), 32'h0);
        chk("dis_sticky",   32'(if_a.err_sticky), 32'h8);
        chk_cnt_a("dis_cnt3", 3, 1);
        chk_cnt_a("dis_cnt2", 2, 0);
        if_a.en = 1'b1;

        // rst during PEND on ch2, then a fresh episode after release
        tick(); tick();
        chk("pend_state", 32'(if_a.state_dbg), 32'h10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_fail_now", 32'(if_a.fail_now), 32'h0);
        chk("rst_sticky",   32'(if_a.err_sticky), 32'h0);
        chk("rst_any_err",  32'(if_a.any_err), 32'h0);
        chk("rst_state",    32'(if_a.state_dbg), 32'h0);
        chk_cnt_a("rst_cnt3", 3, 0);
        tick(); tick(); tick();
        chk("post_rst_fail", 32'(if_a.fail_now), 32'h4);
        chk_cnt_a("post_rst_cnt2", 2, 1);
        if_a.b = B_GOOD;
        tick();

        // TOL=0: one mismatching cycle fails immediately
        if_b.b = 10'h2AB;
        tick();
        chk("tol0_fail_now", 32'(if_b.fail_now), 32'h01);
        chk("tol0_any_err",  32'(if_b.any_err), 32'h1);
        chk_cnt_b("tol0_cnt0", 0, 1);
        if_b.b = 10'h2AA;
        tick();
        chk("tol0_release", 32'(if_b.fail_now), 32'h00);
        chk_cnt_b("sel_out_of_range5", 5, 0);
        chk_cnt_b("sel_out_of_range7", 7, 0);
        chk_cnt_b("sel_ch1", 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
